// File: rtl/lsu_mau_pkg.sv
// Shared definitions for the LSU memory access unit: bus widths, default
// ack timeout and the access FSM state encoding.
package lsu_mau_pkg;

  localparam int unsigned LSU_BYTE_W      = 8;
  localparam int unsigned LSU_ADDR_W      = 16;
  localparam int unsigned LSU_ACK_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/lsu_mau_tmo.sv
// Bus ack timeout counter. Counts cycles spent waiting for an ack and flags
// expiry in the ACK_TIMEOUT-th consecutive waiting cycle.
module lsu_mau_tmo #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned    CW    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(ACK_TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Expiry is flagged combinationally in the last allowed waiting cycle so
  // the FSM can leave at the same edge that would complete the count.
  always_comb begin
    expired = en && (cnt == LIMIT);
  end

  // Wait-cycle counter; cleared on reset or state entry, saturates at expiry.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lsu_mau.sv
// LSU memory access unit: runs one 8- or 16-bit load/store as byte
// transactions on an 8-bit req/ack bus, with ack timeout abort.
module lsu_mau
  import lsu_mau_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = LSU_ACK_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LSU_ADDR_W-1:0]   ea,
  input  logic                    start,
  input  logic                    we,
  input  logic                    wide,
  input  logic [2*LSU_BYTE_W-1:0] wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [2*LSU_BYTE_W-1:0] rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [LSU_ADDR_W-1:0]   mem_addr,
  output logic [LSU_BYTE_W-1:0]   mem_wdata,
  input  logic                    mem_ack,
  input  logic [LSU_BYTE_W-1:0]   mem_rdata
);

  state_t                  state, state_nx;
  logic [LSU_ADDR_W-1:0]   ea_q;
  logic [LSU_ADDR_W-1:0]   ea_hi;
  logic                    we_q;
  logic                    wide_q;
  logic [2*LSU_BYTE_W-1:0] wdata_q;
  logic                    tmo_clr;
  logic                    tmo_en;
  logic                    tmo_exp;

  // Wait counter restarts whenever the FSM changes state (entry to LO/HI).
  always_comb begin
    tmo_clr = (state_nx != state);
    tmo_en  = mem_req && !mem_ack;
  end

  lsu_mau_tmo #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(tmo_exp)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; an ack in the expiry cycle takes priority over abort.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_LO;
      ST_LO: begin
        if (mem_ack) state_nx = wide_q ? ST_HI : ST_FIN;
        else if (tmo_exp) state_nx = ST_FIN;
      end
      ST_HI:   if (mem_ack || tmo_exp) state_nx = ST_FIN;
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Bus and status outputs decoded from state; the high byte address wraps.
  always_comb begin
    ea_hi     = ea_q + 1'b1;
    busy      = (state != ST_IDLE);
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_LO: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = ea_q;
        mem_wdata = wdata_q[LSU_BYTE_W-1:0];
      end
      ST_HI: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = ea_hi;
        mem_wdata = wdata_q[2*LSU_BYTE_W-1:LSU_BYTE_W];
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  // Request capture, load data capture and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ea_q    <= '0;
      we_q    <= 1'b0;
      wide_q  <= 1'b0;
      wdata_q <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ea_q    <= ea;
            we_q    <= we;
            wide_q  <= wide;
            wdata_q <= wdata;
            rdata   <= '0;
            err     <= 1'b0;
          end
        end
        ST_LO: begin
          if (mem_ack) begin
            if (!we_q) rdata[LSU_BYTE_W-1:0] <= mem_rdata;
          end else if (tmo_exp) begin
            err <= 1'b1;
          end
        end
        ST_HI: begin
          if (mem_ack) begin
            if (!we_q) rdata[2*LSU_BYTE_W-1:LSU_BYTE_W] <= mem_rdata;
          end else if (tmo_exp) begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mau.sv
// Scoreboard bench for lsu_mau: stimulus pushes expected bus bytes and
// completion results; a bus slave and a done monitor pop and compare.
module tb_lsu_mau;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } bus_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          t0;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ea = '0;
  logic        start = 1'b0;
  logic        we = 1'b0;
  logic        wide = 1'b0;
  logic [15:0] wdata = '0;
  logic        busy, done, err;
  logic [15:0] rdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;

  bus_t       busq[$];
  res_t       resq[$];
  logic [7:0] rdq[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int wait_n = 0;
  int wcnt = 0;
  bit no_ack = 1'b0;

  lsu_mau #(.ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .ea(ea), .start(start), .we(we), .wide(wide),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Bus slave: acks after wait_n wait cycles and checks each acked byte.
  always @(negedge clk) begin : slave
    bus_t b;
    if (mem_req && !no_ack && wcnt == wait_n) begin
      mem_ack   = 1'b1;
      mem_rdata = (rdq.size() != 0) ? rdq.pop_front() : 8'h00;
      wcnt      = 0;
      if (busq.size() == 0) begin
        chk("bus_unexpected", 1, 0);
      end else begin
        b = busq.pop_front();
        chk("bus_addr", mem_addr, b.addr);
        chk("bus_we", mem_we, b.we);
        chk("bus_wdata", mem_wdata, b.wdata);
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      wcnt      = mem_req ? wcnt + 1 : 0;
    end
  end

  // Completion monitor: checks result, error flag and latency on each done.
  always @(negedge clk) begin : mon
    res_t e;
    if (done) begin
      done_cnt++;
      if (resq.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        e = resq.pop_front();
        chk("rdata", rdata, e.rdata);
        chk("err", err, e.err);
        chk("latency", cyc - e.t0, e.lat);
      end
    end
  end

  task automatic drive_start(input logic [15:0] a, input logic w, input logic wd,
                             input logic [15:0] d);
    @(negedge clk);
    ea = a; we = w; wide = wd; wdata = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input logic [15:0] a, input logic w, input logic wd,
                       input logic [15:0] d, input logic [15:0] exp_rd,
                       input logic exp_err, input int lat);
    @(negedge clk);
    ea = a; we = w; wide = wd; wdata = d; start = 1'b1;
    resq.push_back('{exp_rd, exp_err, lat, cyc});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string nm, input int n);
    repeat (n) @(negedge clk);
    chk(nm, resq.size(), 0);
  endtask

  initial begin : wdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst = 1'b0;

    // 1: narrow load, zero-wait
    wait_n = 0;
    rdq.push_back(8'hAB);
    busq.push_back('{16'h1234, 1'b0, 8'h00});
    issue(16'h1234, 1'b0, 1'b0, 16'h0000, 16'h00AB, 1'b0, 2);
    drain("t1_missing_done", 5);

    // 2: wide store, two wait states per byte
    wait_n = 2;
    busq.push_back('{16'h2000, 1'b1, 8'hEF});
    busq.push_back('{16'h2001, 1'b1, 8'hBE});
    issue(16'h2000, 1'b1, 1'b1, 16'hBEEF, 16'h0000, 1'b0, 7);
    drain("t2_missing_done", 10);

    // 3: wide load across the address wrap
    wait_n = 0;
    rdq.push_back(8'h11);
    rdq.push_back(8'h22);
    busq.push_back('{16'hFFFF, 1'b0, 8'h00});
    busq.push_back('{16'h0000, 1'b0, 8'h00});
    issue(16'hFFFF, 1'b0, 1'b1, 16'h0000, 16'h2211, 1'b0, 3);
    drain("t3_missing_done", 5);

    // 4a: no ack, abort after 15 request cycles
    no_ack = 1'b1;
    issue(16'h4000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16);
    drain("t4a_missing_done", 20);
    no_ack = 1'b0;

    // 4b: ack on the 15th request cycle wins over the timeout
    wait_n = 14;
    rdq.push_back(8'hC3);
    busq.push_back('{16'h4000, 1'b0, 8'h00});
    issue(16'h4000, 1'b0, 1'b0, 16'h0000, 16'h00C3, 1'b0, 16);
    drain("t4b_missing_done", 20);

    // 5: start during LO and FIN is ignored
    wait_n = 2;
    rdq.push_back(8'h5E);
    busq.push_back('{16'h5000, 1'b0, 8'h00});
    issue(16'h5000, 1'b0, 1'b0, 16'h0000, 16'h005E, 1'b0, 4);
    chk("t5_busy_c1", busy, 1);
    @(negedge clk);
    ea = 16'h5555; start = 1'b1;
    chk("t5_busy_c2", busy, 1);
    @(negedge clk);
    start = 1'b0;
    chk("t5_busy_c3", busy, 1);
    @(negedge clk);
    start = 1'b1;
    chk("t5_busy_fin", busy, 1);
    @(negedge clk);
    start = 1'b0;
    chk("t5_busy_idle", busy, 0);
    @(negedge clk);
    chk("t5_busy_idle2", busy, 0);
    drain("t5_missing_done", 4);

    // 6: reset during HI of a wide load, then a normal access
    wait_n = 3;
    rdq.push_back(8'h5A);
    rdq.push_back(8'h77);
    busq.push_back('{16'h3000, 1'b0, 8'h00});
    drive_start(16'h3000, 1'b0, 1'b1, 16'h0000);
    repeat (5) @(negedge clk);
    chk("t6_hi_addr", mem_addr, 16'h3001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_req_after_rst", mem_req, 0);
    chk("t6_busy_after_rst", busy, 0);
    chk("t6_rdata_after_rst", rdata, 0);
    rdq.delete();
    @(negedge clk);
    wait_n = 0;
    rdq.push_back(8'h99);
    busq.push_back('{16'h3100, 1'b0, 8'h00});
    issue(16'h3100, 1'b0, 1'b0, 16'h0000, 16'h0099, 1'b0, 2);
    drain("t6_missing_done", 5);

    chk("bus_left", busq.size(), 0);
    chk("done_total", done_cnt, 7);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
